alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative multi-cycle multiply/divide unit, parametrised in data width, that executes the RV32M operations next to the single-cycle ALU in the execute stage. It takes one operation at a time through a valid/ready handshake, computes one bit per cycle with a shift-add or shift-subtract datapath, and holds the result until the consumer accepts it. RISC-V corner cases (divide by zero, signed overflow) are resolved in hardware. The core stalls on it.

## Interface
- DataWidth, 32: operand and result width; must be even and ≥ 8.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- src1_i  input  DataWidth  rs1 operand (multiplicand / dividend).
- src2_i  input  DataWidth  rs2 operand (multiplier / divisor).
- md_op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- kill_i  input  1  synchronous abort of the in-flight operation (pipeline flush).
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  DataWidth  result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: ready_o=1. When valid_i=1, capture operands and op, take magnitudes of signed operands, record sign fix-up flags, load counter with DataWidth, go to BUSY.
- BUSY: one iteration per cycle; counter decrements; at counter==1 the final iteration completes and the FSM goes to DONE.
- Multiply: unsigned shift-add on the magnitudes into a 2·DataWidth product. Negate the product when exactly one signed operand is negative. MULHSU treats src2 as unsigned. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring shift-subtract on the magnitudes. Quotient is negated when the signs differ (signed ops). Remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = src1 (signed and unsigned).
- Signed overflow (src1 = most negative, src2 = −1): DIV returns src1, REM returns 0.
- DONE: valid_o=1 and result_o is stable. When ready_i=1, go to IDLE. A new request can be accepted no earlier than the next cycle.
- kill_i=1 in any state forces IDLE on the next edge, with no valid_o. It has priority over valid_i and ready_i in the same cycle.
- Reset: state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0, internal registers=0.

## Timing
- Request is accepted on edge N (valid_i && ready_o). The FSM is in BUSY from N through edge N+DataWidth. valid_o=1 from edge N+DataWidth, so latency is DataWidth cycles from acceptance to the first result cycle.
- ready_o and valid_o are never high together. ready_o is a pure function of state.
- src1_i, src2_i and md_op_i are sampled only at acceptance. Changes afterwards have no effect.
- valid_o stays high indefinitely while ready_i=0.
- Reset asserted mid-operation clears everything immediately (asynchronously). The first acceptance is possible on the first edge after rst_ni rises.

## Configuration
- ALU_MULDIV_EARLY_OUT_EN defined:
  - Divide by zero, signed overflow, and any op with src1=0 skip iteration. They occupy one BUSY cycle, so valid_o rises at edge N+1.
- Undefined:
  - Every op takes the full DataWidth BUSY cycles.
- Results are identical either way. Only latency differs.

## Test plan
- MUL 7×(−3) with DataWidth=32 → result 0xFFFFFFEB. valid_o rises exactly 32 cycles after acceptance.
- MULH, MULHSU, MULHU with src1=0x80000000, src2=0xFFFFFFFF → 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF. REMU of the same → 0xF.
- DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. REM of the same → 0. Latency is 1 with ALU_MULDIV_EARLY_OUT_EN and 32 without.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → valid_o and result_o stay stable and ready_o stays 0. Raise ready_i → IDLE next cycle and ready_o=1.
- Assert kill_i at BUSY cycle 5, then deassert rst_ni mid-BUSY on a second request:
  - kill_i → no valid_o, and the unit is IDLE next cycle.
  - Reset → all outputs at reset values immediately. A fresh MUL 3×4 then returns 12.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Define ALU_MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and src1==0 in one BUSY cycle.
module alu_muldiv #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] src1_i,
  input  logic [DataWidth-1:0] src2_i,
  input  logic [2:0]           md_op_i,
  input  logic                 kill_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] result_o
);
  localparam int W = DataWidth;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic neg_q, spec_q;
  logic [W-1:0] spec_res_q, hi_q, lo_q, b_q;
  logic is_div, a_sgn, b_sgn, a_neg, b_neg, dz, ovf, spec;
  logic [W-1:0] a_mag, b_mag, spec_res;
  logic [W:0] sum, shifted, sub;
  logic [W-1:0] nhi, nlo, quo, rem;
  logic [2*W-1:0] prod;
  logic [W-1:0] fin;
  assign ready_o = state == IDLE;
  assign valid_o = state == DONE;
  always_comb begin
    is_div = md_op_i[2];
    a_sgn = is_div ? ~md_op_i[0] : (md_op_i == 3'd1 || md_op_i == 3'd2);
    b_sgn = is_div ? ~md_op_i[0] : (md_op_i == 3'd1);
    a_neg = a_sgn & src1_i[W-1];
    b_neg = b_sgn & src2_i[W-1];
    a_mag = a_neg ? -src1_i : src1_i;
    b_mag = b_neg ? -src2_i : src2_i;
    dz = is_div && src2_i == '0;
    ovf = is_div && !md_op_i[0] && src1_i == {1'b1, {(W-1){1'b0}}} && &src2_i;
    spec = dz || ovf || src1_i == '0;
    spec_res = dz ? (md_op_i[1] ? src1_i : '1) : ovf ? (md_op_i[1] ? '0 : src1_i) : '0;
  end
  // multiply: hi accumulates, lo shifts out the multiplier; divide: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[W-1]};
    sub = shifted - {1'b0, b_q};
    nhi = op_q[2] ? (sub[W] ? shifted[W-1:0] : sub[W-1:0]) : sum[W:1];
    nlo = op_q[2] ? {lo_q[W-2:0], ~sub[W]} : {sum[0], lo_q[W-1:1]};
    prod = neg_q ? -{nhi, nlo} : {nhi, nlo};
    quo = neg_q ? -nlo : nlo;
    rem = neg_q ? -nhi : nhi;
    fin = spec_q ? spec_res_q : op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[W-1:0] : prod[2*W-1:W]);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      spec_q <= 1'b0;
      spec_res_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      result_o <= '0;
    end else if (kill_i) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE && valid_i) begin
      state <= BUSY;
      op_q <= md_op_i;
      neg_q <= (is_div && md_op_i[1]) ? a_neg : a_neg ^ b_neg;
      spec_q <= spec;
      spec_res_q <= spec_res;
      hi_q <= '0;
      lo_q <= is_div ? a_mag : b_mag;
      b_q <= is_div ? b_mag : a_mag;
      cnt <= (EarlyOut && spec) ? CW'(1) : CW'(W);
    end else if (state == BUSY) begin
      hi_q <= nhi;
      lo_q <= nlo;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= DONE;
        result_o <= fin;
      end
    end else if (state == DONE && ready_i) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed RV32M vectors, latency, backpressure, kill and async reset checks for alu_muldiv.
module tb_alu_muldiv;
  localparam int W = 32;
`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = W;
`endif
  logic clk = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b0;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic [2:0] md_op_i = '0;
  logic ready_o, valid_o;
  logic [W-1:0] result_o;
  int errs = 0, checks = 0;
  alu_muldiv #(.DataWidth(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .md_op_i(md_op_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!ready_o && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    md_op_i = op;
    src1_i = a;
    src2_i = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    src1_i = ~a;
    src2_i = b + 32'd1;
    md_op_i = op ^ 3'd1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid_o && n < 200);
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input int lat);
    int n;
    accept(op, a, b);
    check({tag, " busy"}, {valid_o, ready_o}, 2'b00);
    wait_valid(n);
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, result_o, exp);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check({tag, " idle"}, {valid_o, ready_o}, 2'b01);
  endtask
  initial begin
    int n, seen;
    #12;
    check("reset outputs", {ready_o, valid_o, result_o}, {2'b10, 32'h0});
    @(negedge clk);
    rst_ni = 1'b1;
    run("mul 7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, W);
    run("mulh", 3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, W);
    run("mulhsu", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, W);
    run("mulhu", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, W);
    run("mulhu max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W);
    run("mul max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, W);
    run("div -7/2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, W);
    run("rem -7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, W);
    run("div 7/-2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, W);
    run("rem 7/-2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'h00000001, W);
    run("divu", 3'd5, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, W);
    run("remu", 3'd7, 32'hFFFFFFFF, 32'h10, 32'h0000000F, W);
    run("div 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, SPL);
    run("rem 5/0", 3'd6, 32'd5, 32'd0, 32'd5, SPL);
    run("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, SPL);
    run("remu 5/0", 3'd7, 32'd5, 32'd0, 32'd5, SPL);
    run("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPL);
    run("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPL);
    run("mul 0x5", 3'd0, 32'd0, 32'd5, 32'd0, SPL);
    accept(3'd0, 32'd6, 32'd7);
    wait_valid(n);
    check("bp latency", n, W);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp hold", {valid_o, ready_o, result_o}, {2'b10, 32'd42});
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check("bp release", {valid_o, ready_o}, 2'b01);
    accept(3'd0, 32'd9, 32'd9);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    kill_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    valid_i = 1'b0;
    check("kill idle", {valid_o, ready_o}, 2'b01);
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("kill no valid", seen, 0);
    accept(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("async reset", {ready_o, valid_o, result_o}, {2'b10, 32'h0});
    @(negedge clk);
    rst_ni = 1'b1;
    run("mul 3x4", 3'd0, 32'd3, 32'd4, 32'd12, W);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
